// File: rtl/enc_pkg.sv
// Shared definitions for the encoder position tracker: step codes,
// default timing constants and the saturating step-add helper.
package enc_pkg;

  // Step codes produced from the plus1/minus1 pulse pair
  localparam logic [1:0] DELTA_NONE = 2'b00;
  localparam logic [1:0] DELTA_FWD  = 2'b01;
  localparam logic [1:0] DELTA_REV  = 2'b11;

  localparam int DEFAULT_WINDOW      = 1000;
  localparam int DEFAULT_IDLE_CYCLES = 100000;

  // Width used for intermediate saturating arithmetic (holds any VEL_W < 64)
  localparam int SAT_CALC_W = 64;

  // Both pulses together cancel out and count as no step
  function automatic logic [1:0] decode_step(input logic up, input logic dn);
    logic [1:0] code;
    code = DELTA_NONE;
    if (up && !dn) begin
      code = DELTA_FWD;
    end else if (dn && !up) begin
      code = DELTA_REV;
    end
    return code;
  endfunction

  // Apply a step code to a value and clamp into the signed range of width w
  function automatic logic signed [SAT_CALC_W-1:0] sat_add(
    input logic signed [SAT_CALC_W-1:0] a,
    input logic [1:0]                   code,
    input int                           w
  );
    logic signed [SAT_CALC_W-1:0] hi;
    logic signed [SAT_CALC_W-1:0] lo;
    logic signed [SAT_CALC_W-1:0] r;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    r  = a;
    if (code == DELTA_FWD) begin
      r = a + 64'sd1;
    end else if (code == DELTA_REV) begin
      r = a - 64'sd1;
    end
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/enc_rate_window.sv
// Windowed velocity: counts net steps over WINDOW cycles with a saturating
// accumulator and publishes the total once per window.
module enc_rate_window
  import enc_pkg::*;
#(
  parameter int VEL_W  = 16,
  parameter int WINDOW = DEFAULT_WINDOW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              delta,
  output logic signed [VEL_W-1:0] vel,
  output logic                    vel_valid
);

  localparam int               CNT_W    = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  logic [CNT_W-1:0]        r_cnt;
  logic signed [VEL_W-1:0] r_acc;
  logic signed [VEL_W-1:0] r_vel;
  logic                    r_vel_valid;
  logic signed [VEL_W-1:0] w_acc_next;

  // Accumulator including this cycle's step, clamped to the result range
  always_comb begin
    w_acc_next = VEL_W'(sat_add(SAT_CALC_W'(r_acc), delta, VEL_W));
  end

  // Window counter; on the last cycle publish the total and start afresh
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_vel       <= '0;
      r_vel_valid <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_vel       <= w_acc_next;
      r_vel_valid <= 1'b1;
      r_acc       <= '0;
      r_cnt       <= '0;
    end else begin
      r_acc       <= w_acc_next;
      r_vel_valid <= 1'b0;
      r_cnt       <= r_cnt + CNT_W'(1);
    end
  end

  assign vel       = r_vel;
  assign vel_valid = r_vel_valid;

endmodule

// File: rtl/enc_position_tracker.sv
// Encoder position tracker: absolute position with preset, windowed
// velocity, direction and idle status from decoder step pulses.
// Optional macro ENC_TRACKER_LIMITS_EN replaces wrapping with saturation
// against run-time bounds pos_min/pos_max and adds at_min/at_max flags.
module enc_position_tracker
  import enc_pkg::*;
#(
  parameter int POS_W       = 32,
  parameter int VEL_W       = 16,
  parameter int WINDOW      = DEFAULT_WINDOW,
  parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    plus1,
  input  logic                    minus1,
  input  logic                    load,
  input  logic signed [POS_W-1:0] load_val,
`ifdef ENC_TRACKER_LIMITS_EN
  input  logic signed [POS_W-1:0] pos_min,
  input  logic signed [POS_W-1:0] pos_max,
  output logic                    at_min,
  output logic                    at_max,
`endif
  output logic signed [POS_W-1:0] pos,
  output logic                    pos_wrap,
  output logic signed [VEL_W-1:0] vel,
  output logic                    vel_valid,
  output logic                    dir,
  output logic                    moving
);

  localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  localparam int                      IDLE_W  = $clog2(IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0]       IDLE_LIMIT = IDLE_W'(IDLE_CYCLES);

  logic signed [POS_W-1:0] r_pos;
  logic                    r_wrap;
  logic                    r_dir;
  logic                    r_moving;
  logic [IDLE_W-1:0]       r_idle;
  logic [1:0]              w_delta;
  logic                    w_step;
  logic signed [POS_W-1:0] w_pos_next;
  logic                    w_wrap_next;

  assign w_delta = decode_step(plus1, minus1);
  assign w_step  = (w_delta != DELTA_NONE);

  // Next position: preset wins over a step; otherwise wrap or clamp the step
  always_comb begin
    w_pos_next  = r_pos;
    w_wrap_next = 1'b0;
`ifdef ENC_TRACKER_LIMITS_EN
    if (load) begin
      if (load_val < pos_min) begin
        w_pos_next = pos_min;
      end else if (load_val > pos_max) begin
        w_pos_next = pos_max;
      end else begin
        w_pos_next = load_val;
      end
    end else if (w_delta == DELTA_FWD && r_pos < pos_max) begin
      w_pos_next = r_pos + POS_W'(1);
    end else if (w_delta == DELTA_REV && r_pos > pos_min) begin
      w_pos_next = r_pos - POS_W'(1);
    end
`else
    if (load) begin
      w_pos_next = load_val;
    end else if (w_delta == DELTA_FWD) begin
      w_pos_next  = r_pos + POS_W'(1);
      w_wrap_next = (r_pos == POS_MAX);
    end else if (w_delta == DELTA_REV) begin
      w_pos_next  = r_pos - POS_W'(1);
      w_wrap_next = (r_pos == POS_MIN);
    end
`endif
  end

  // Position register and its wrap pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_pos  <= w_pos_next;
      r_wrap <= w_wrap_next;
    end
  end

  // Direction of last real step and idle timeout for the moving flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir    <= 1'b1;
      r_moving <= 1'b0;
      r_idle   <= '0;
    end else if (w_step) begin
      r_dir    <= (w_delta == DELTA_FWD);
      r_moving <= 1'b1;
      r_idle   <= '0;
    end else if (r_idle != IDLE_LIMIT) begin
      r_idle <= r_idle + IDLE_W'(1);
      if (r_idle + IDLE_W'(1) == IDLE_LIMIT) begin
        r_moving <= 1'b0;
      end
    end
  end

  enc_rate_window #(
    .VEL_W  (VEL_W),
    .WINDOW (WINDOW)
  ) u_rate (
    .clk       (clk),
    .rst       (rst),
    .delta     (w_delta),
    .vel       (vel),
    .vel_valid (vel_valid)
  );

  assign pos      = r_pos;
  assign pos_wrap = r_wrap;
  assign dir      = r_dir;
  assign moving   = r_moving;
`ifdef ENC_TRACKER_LIMITS_EN
  assign at_min   = (r_pos == pos_min);
  assign at_max   = (r_pos == pos_max);
`endif

endmodule

// File: tb/tb_enc_position_tracker.sv
// Self-checking bench for enc_position_tracker: directed steps followed by
// random pulses, compared every cycle against an arithmetic reference model.
module tb_enc_position_tracker;

  localparam int POS_W = 8;
  localparam int VEL_W = 4;
  localparam int WINDOW = 10;
  localparam int IDLE = 20;
  localparam int PLO = -(1 << (POS_W - 1));
  localparam int PHI = (1 << (POS_W - 1)) - 1;
  localparam int VLO = -(1 << (VEL_W - 1));
  localparam int VHI = (1 << (VEL_W - 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic plus1 = 1'b0;
  logic minus1 = 1'b0;
  logic load = 1'b0;
  logic signed [POS_W-1:0] load_val = '0;
  logic signed [POS_W-1:0] pos;
  logic pos_wrap;
  logic signed [VEL_W-1:0] vel;
  logic vel_valid;
  logic dir;
  logic moving;
`ifdef ENC_TRACKER_LIMITS_EN
  logic signed [POS_W-1:0] pos_min = -8'sd3;
  logic signed [POS_W-1:0] pos_max = 8'sd3;
  logic at_min;
  logic at_max;
`endif

  enc_position_tracker #(
    .POS_W(POS_W), .VEL_W(VEL_W), .WINDOW(WINDOW), .IDLE_CYCLES(IDLE)
  ) dut (
    .clk(clk), .rst(rst), .plus1(plus1), .minus1(minus1),
    .load(load), .load_val(load_val),
`ifdef ENC_TRACKER_LIMITS_EN
    .pos_min(pos_min), .pos_max(pos_max), .at_min(at_min), .at_max(at_max),
`endif
    .pos(pos), .pos_wrap(pos_wrap), .vel(vel), .vel_valid(vel_valid),
    .dir(dir), .moving(moving)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  // Reference model state: k counts clock edges since reset released
  int m_pos, m_wrap, m_dir, m_vel, m_vvalid, m_acc, m_k, m_last;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int wrap_pos(input int v);
    int span;
    span = 1 << POS_W;
    return ((v - PLO) % span + span) % span + PLO;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_wrap = 0; m_dir = 1; m_vel = 0; m_vvalid = 0;
    m_acc = 0; m_k = 0; m_last = -1;
  endtask

  task automatic model_step(input int p, input int mi, input int l, input int lv);
    int d;
    int raw;
    d = (p != 0 && mi == 0) ? 1 : ((mi != 0 && p == 0) ? -1 : 0);
    m_k++;
`ifdef ENC_TRACKER_LIMITS_EN
    if (l != 0) m_pos = clamp(lv, int'(pos_min), int'(pos_max));
    else m_pos = clamp(m_pos + d, int'(pos_min), int'(pos_max));
    m_wrap = 0;
`else
    if (l != 0) begin
      m_pos = lv;
      m_wrap = 0;
    end else begin
      raw = m_pos + d;
      m_pos = wrap_pos(raw);
      m_wrap = (raw != m_pos) ? 1 : 0;
    end
`endif
    if (d != 0) begin
      m_dir = (d > 0) ? 1 : 0;
      m_last = m_k;
    end
    m_acc = clamp(m_acc + d, VLO, VHI);
    if (m_k % WINDOW == 0) begin
      m_vel = m_acc;
      m_acc = 0;
      m_vvalid = 1;
    end else begin
      m_vvalid = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    int exp_moving;
    exp_moving = (m_last >= 0 && (m_k - m_last) < IDLE) ? 1 : 0;
    check({tag, ".pos"}, int'(pos), m_pos);
    check({tag, ".pos_wrap"}, int'(pos_wrap), m_wrap);
    check({tag, ".dir"}, int'(dir), m_dir);
    check({tag, ".moving"}, int'(moving), exp_moving);
    check({tag, ".vel_valid"}, int'(vel_valid), m_vvalid);
    check({tag, ".vel"}, int'(vel), m_vel);
`ifdef ENC_TRACKER_LIMITS_EN
    check({tag, ".at_min"}, int'(at_min), (m_pos == int'(pos_min)) ? 1 : 0);
    check({tag, ".at_max"}, int'(at_max), (m_pos == int'(pos_max)) ? 1 : 0);
`endif
  endtask

  // One clock with the given inputs, then model update and full comparison
  task automatic cyc(input string tag, input int p, input int mi, input int l, input int lv);
    plus1 = (p != 0);
    minus1 = (mi != 0);
    load = (l != 0);
    load_val = POS_W'(lv);
    @(posedge clk);
    #1;
    model_step(p, mi, l, int'(load_val));
    compare_all(tag);
    $display("cycle %0d %s: p=%0d m=%0d ld=%0d lv=%0d -> pos=%0d wrap=%0d dir=%0d mov=%0d vv=%0d vel=%0d",
             m_k, tag, p, mi, l, int'(load_val), int'(pos), pos_wrap, dir, moving, vel_valid, int'(vel));
  endtask

  // Reset with busy inputs to show they are ignored
  task automatic do_reset(input string tag);
    rst = 1'b1;
    plus1 = 1'b1; minus1 = 1'b0; load = 1'b1; load_val = 8'sd77;
    @(posedge clk);
    #1;
    rst = 1'b0;
    plus1 = 1'b0; load = 1'b0; load_val = '0;
    model_reset();
    compare_all(tag);
    $display("reset %s: pos=%0d dir=%0d mov=%0d vel=%0d", tag, int'(pos), dir, moving, int'(vel));
  endtask

  initial begin
    model_reset();

    // Reset state
    do_reset("reset0");
    check("reset0.pos_const", int'(pos), 0);
    check("reset0.dir_const", int'(dir), 1);

    // Five forward pulses three cycles apart
    for (int i = 0; i < 5; i++) begin
      cyc("fwd5", 1, 0, 0, 0);
      if (i < 4) begin
        cyc("fwd5_gap", 0, 0, 0, 0);
        cyc("fwd5_gap", 0, 0, 0, 0);
      end
    end
    check("fwd5.pos_const", int'(pos), 5);
    check("fwd5.dir_const", int'(dir), 1);
    check("fwd5.moving_const", int'(moving), 1);

    // Velocity window: 4 forward, 1 reverse in first window, then silence
    do_reset("win_rst");
    for (int k = 1; k <= WINDOW; k++) begin
      cyc("win1", (k == 1 || k == 3 || k == 5 || k == 7) ? 1 : 0, (k == 8) ? 1 : 0, 0, 0);
      if (k < WINDOW) check("win1.no_valid_early", int'(vel_valid), 0);
    end
    check("win1.vel_valid_const", int'(vel_valid), 1);
    check("win1.vel_const", int'(vel), 3);
    cyc("win2", 0, 0, 0, 0);
    check("win2.valid_drop", int'(vel_valid), 0);
    check("win2.vel_hold", int'(vel), 3);
    for (int k = 2; k <= WINDOW; k++) cyc("win2", 0, 0, 0, 0);
    check("win2.vel_zero", int'(vel), 0);

    // Accumulator saturation at both ends of the velocity range
    for (int k = 0; k < WINDOW; k++) cyc("sat_hi", 1, 0, 0, 0);
    check("sat_hi.vel_const", int'(vel), VHI);
    for (int k = 0; k < WINDOW; k++) cyc("sat_lo", 0, 1, 0, 0);
    check("sat_lo.vel_const", int'(vel), VLO);

`ifndef ENC_TRACKER_LIMITS_EN
    // Two's-complement wrap in both directions
    cyc("wrap_load", 0, 0, 1, PHI);
    cyc("wrap_up", 1, 0, 0, 0);
    check("wrap_up.pos_const", int'(pos), PLO);
    check("wrap_up.wrap_const", int'(pos_wrap), 1);
    cyc("wrap_up_after", 0, 0, 0, 0);
    check("wrap_up.pulse_len", int'(pos_wrap), 0);
    cyc("wrap_load2", 0, 0, 1, PLO);
    cyc("wrap_dn", 0, 1, 0, 0);
    check("wrap_dn.pos_const", int'(pos), PHI);
    check("wrap_dn.wrap_const", int'(pos_wrap), 1);
`else
    // Bounded position: saturate at pos_max and clamp out-of-range presets
    cyc("lim_zero", 0, 0, 1, 0);
    for (int k = 0; k < 6; k++) cyc("lim_up", 1, 0, 0, 0);
    check("lim_up.pos_const", int'(pos), 3);
    check("lim_up.at_max_const", int'(at_max), 1);
    check("lim_up.wrap_const", int'(pos_wrap), 0);
    cyc("lim_load", 0, 0, 1, 10);
    check("lim_load.pos_const", int'(pos), 3);
`endif

    // Load beats a coincident step; both pulses together are not a step
    cyc("load_step", 1, 0, 1, 50);
    check("load_step.pos_const", int'(pos), 50);
    cyc("rev", 0, 1, 0, 0);
    cyc("both", 1, 1, 0, 0);
    check("both.dir_const", int'(dir), 0);
`ifndef ENC_TRACKER_LIMITS_EN
    check("both.pos_const", int'(pos), 49);
`endif

    // Idle timeout measured from a single step
    do_reset("idle_rst");
    cyc("idle_step", 1, 0, 0, 0);
    for (int k = 1; k < IDLE; k++) cyc("idle_wait", 0, 0, 0, 0);
    check("idle.still_moving", int'(moving), 1);
    cyc("idle_edge", 0, 0, 0, 0);
    check("idle.stopped", int'(moving), 0);

    // Random pulses, occasional presets, one reset mid-window
    for (int i = 0; i < 400; i++) begin
      int p;
      int mi;
      int l;
      int lv;
      p = ($urandom_range(0, 2) == 0) ? 1 : 0;
      mi = ($urandom_range(0, 3) == 0) ? 1 : 0;
      l = ($urandom_range(0, 24) == 0) ? 1 : 0;
      lv = int'($urandom_range(0, 255)) + PLO;
      if (i == 203) do_reset("rand_mid_rst");
      else if (i > 300 && i < 330) cyc("rand_quiet", 0, 0, 0, 0);
      else cyc("rand", p, mi, l, lv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
